store_trace_buffer: RTL and testbench

STORE_TRACE_BUFFER -- requirements
Module: store_trace_buffer

---
 rtl/trace_pkg.sv | 24 ++
 rtl/trace_fifo.sv | 68 ++++++
 rtl/store_trace_buffer.sv | 124 ++++++++++++
 tb/tb_store_trace_buffer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared definitions for the store trace buffer.
// Contents:
//   state_t       - capture/drain/done controller states
//   trace_entry_t - one captured store, {addr, data}, at the default width
//   DEFAULT_N     - default address/data width
//   DEFAULT_DEPTH - default number of trace entries
package trace_pkg;

  localparam int DEFAULT_N     = 64;
  localparam int DEFAULT_DEPTH = 16;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Storage packs entries with the address in the upper half, matching this layout.
  typedef struct packed {
    logic [DEFAULT_N-1:0] addr;
    logic [DEFAULT_N-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Circular entry storage for the store trace buffer.
// Synchronous write at the tail, asynchronous read of the head entry.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (pointers/count only)
//   i_push    - write i_wdata at the tail (ignored when full)
//   i_pop     - discard the head entry (ignored when empty)
//   i_wdata   - entry to write
//   o_rdata   - current head entry
//   o_count   - entries held
//   o_full    - count == DEPTH
//   o_empty   - count == 0
module trace_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_wdata,
  output logic [W-1:0]               o_rdata,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // DEPTH is a power of two, so pointer wrap is the natural PW-bit rollover;
  // full/empty are taken from the count, never from pointer equality.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= i_wdata;
  end

  assign o_rdata = r_mem[r_head];
  assign o_count = r_count;

endmodule

// File: rtl/store_trace_buffer.sv
// Store trace buffer: captures processor data-memory stores until a dump
// request, then drains the captured entries oldest-first over a
// valid/ready stream, then stays idle until reset.
// Ports:
//   CLOCK_50, reset          - clock, asynchronous active-high reset
//   DM_writeEnable/addr/Data - store strobe, address and data being traced
//   dump                     - level request; its rising edge stops capture
//   trace_valid/ready        - output handshake for drained entries
//   trace_addr/data/last     - head entry, and marker for the final entry
//   count                    - entries currently held
//   overflow, drop_count     - sticky drop flag and saturating drop count
//   busy                     - high while draining
module store_trace_buffer
  import trace_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       DM_writeEnable,
  input  logic [N-1:0]               DM_addr,
  input  logic [N-1:0]               DM_writeData,
  input  logic                       dump,
  output logic                       trace_valid,
  input  logic                       trace_ready,
  output logic [N-1:0]               trace_addr,
  output logic [N-1:0]               trace_data,
  output logic                       trace_last,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic [15:0]                drop_count,
  output logic                       busy
);

  localparam int CW = $clog2(DEPTH+1);

  state_t          r_state;
  state_t          w_state_next;
  logic            r_dump_prev;
  logic            w_dump_edge;
  logic            w_store_req;
  logic            w_push;
  logic            w_drop;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  logic [2*N-1:0]  w_head;
  logic            r_overflow;
  logic [15:0]     r_drop_count;

  // Previous dump sample resets to 0, so a dump held through reset is seen
  // as an edge on the first sampled 1.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) r_dump_prev <= 1'b0;
    else       r_dump_prev <= dump;
  end
  assign w_dump_edge = dump && !r_dump_prev;

  assign w_store_req = (r_state == CAPTURE) && DM_writeEnable;
  assign w_push      = w_store_req && !w_full;
  assign w_drop      = w_store_req && w_full;
  assign w_pop       = trace_valid && trace_ready;

  trace_fifo #(
    .W     (2*N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLOCK_50),
    .rst     (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({DM_addr, DM_writeData}),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) r_state <= CAPTURE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    trace_valid  = 1'b0;
    trace_last   = 1'b0;
    busy         = 1'b0;
    case (r_state)
      CAPTURE: begin
        // A store accepted on the dump edge still needs draining, even if
        // the buffer was empty before it.
        if (w_dump_edge) w_state_next = (!w_empty || w_push) ? DRAIN : DONE;
      end
      DRAIN: begin
        busy        = 1'b1;
        trace_valid = !w_empty;
        trace_last  = !w_empty && (w_count == CW'(1));
        if (w_pop && (w_count == CW'(1))) w_state_next = DONE;
      end
      DONE:    w_state_next = DONE;
      default: w_state_next = CAPTURE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= 16'd0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign trace_addr = w_head[2*N-1:N];
  assign trace_data = w_head[N-1:0];
  assign count      = w_count;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_store_trace_buffer.sv
module tb_store_trace_buffer;
  import trace_pkg::*;

  localparam int N     = 64;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH+1);

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b1;
  logic          DM_writeEnable = 1'b0;
  logic [N-1:0]  DM_addr = '0;
  logic [N-1:0]  DM_writeData = '0;
  logic          dump = 1'b0;
  logic          trace_valid;
  logic          trace_ready = 1'b0;
  logic [N-1:0]  trace_addr;
  logic [N-1:0]  trace_data;
  logic          trace_last;
  logic [CW-1:0] count;
  logic          overflow;
  logic [15:0]   drop_count;
  logic          busy;

  int n_assert = 0;
  int n_fail   = 0;
  int m_drops  = 0;
  trace_entry_t sb[$];

  store_trace_buffer #(.N(N), .DEPTH(DEPTH)) dut (
    .CLOCK_50       (CLOCK_50),
    .reset          (reset),
    .DM_writeEnable (DM_writeEnable),
    .DM_addr        (DM_addr),
    .DM_writeData   (DM_writeData),
    .dump           (dump),
    .trace_valid    (trace_valid),
    .trace_ready    (trace_ready),
    .trace_addr     (trace_addr),
    .trace_data     (trace_data),
    .trace_last     (trace_last),
    .count          (count),
    .overflow       (overflow),
    .drop_count     (drop_count),
    .busy           (busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic apply_reset(input bit hold_dump);
    reset = 1'b1;
    dump = hold_dump;
    trace_ready = 1'b0;
    DM_writeEnable = 1'b0;
    #2;
    chk("rst_valid", 128'(trace_valid), 128'(0));
    chk("rst_last",  128'(trace_last),  128'(0));
    chk("rst_busy",  128'(busy),        128'(0));
    chk("rst_count", 128'(count),       128'(0));
    tick();
    tick();
    reset = 1'b0;
    sb.delete();
    m_drops = 0;
    chk("rst_ovf",  128'(overflow),   128'(0));
    chk("rst_drop", 128'(drop_count), 128'(0));
    $display("reset released (dump=%0d)", hold_dump);
  endtask

  task automatic store(input logic [N-1:0] a, input logic [N-1:0] d);
    trace_entry_t e;
    DM_writeEnable = 1'b1;
    DM_addr = a;
    DM_writeData = d;
    e.addr = a;
    e.data = d;
    if (sb.size() < DEPTH) sb.push_back(e);
    else m_drops++;
    tick();
    DM_writeEnable = 1'b0;
    $display("store addr=0x%0h data=0x%0h count=%0d", a, d, count);
  endtask

  task automatic do_dump(input bit with_store, input logic [N-1:0] a, input logic [N-1:0] d);
    trace_entry_t e;
    dump = 1'b1;
    if (with_store) begin
      DM_writeEnable = 1'b1;
      DM_addr = a;
      DM_writeData = d;
      e.addr = a;
      e.data = d;
      if (sb.size() < DEPTH) sb.push_back(e);
      else m_drops++;
    end
    tick();
    dump = 1'b0;
    DM_writeEnable = 1'b0;
    chk("dump_busy", 128'(busy), 128'(sb.size() > 0));
    $display("dump edge, %0d entries expected", sb.size());
  endtask

  // Stall for 'stall' cycles checking the head is held, then accept up to
  // max_beats entries. With noise set, stores and dump edges are thrown at
  // the DUT during the drain; they must not appear.
  task automatic drain(input int stall, input int max_beats, input bit noise);
    trace_entry_t e;
    int beats = 0;
    trace_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      chk("stall_valid", 128'(trace_valid), 128'(1));
      chk("stall_addr",  128'(trace_addr),  128'(sb[0].addr));
      chk("stall_data",  128'(trace_data),  128'(sb[0].data));
      tick();
    end
    trace_ready = 1'b1;
    for (int cyc = 0; cyc < 3*DEPTH && beats < max_beats; cyc++) begin
      if (noise) begin
        DM_writeEnable = 1'b1;
        DM_addr = {32'hDEAD0000, $urandom};
        DM_writeData = {32'hBAD00000, $urandom};
        dump = ~dump;
      end
      if (!trace_valid) break;
      if (sb.size() == 0) begin
        chk("extra_beat", 128'(1), 128'(0));
        break;
      end
      e = sb.pop_front();
      chk("beat_addr",  128'(trace_addr), 128'(e.addr));
      chk("beat_data",  128'(trace_data), 128'(e.data));
      chk("beat_last",  128'(trace_last), 128'(sb.size() == 0));
      chk("beat_count", 128'(count),      128'(sb.size() + 1));
      $display("beat addr=0x%0h data=0x%0h last=%0d", trace_addr, trace_data, trace_last);
      tick();
      beats++;
    end
    trace_ready = 1'b0;
    DM_writeEnable = 1'b0;
    dump = 1'b0;
  endtask

  task automatic end_checks();
    chk("sb_left",    128'(sb.size()),   128'(0));
    chk("done_valid", 128'(trace_valid), 128'(0));
    chk("done_busy",  128'(busy),        128'(0));
    chk("done_count", 128'(count),       128'(0));
  endtask

  initial begin
    // Three stores, drain in order, then DONE ignores stores.
    apply_reset(1'b0);
    store(64'h10, 64'hAA);
    store(64'h18, 64'hBB);
    store(64'h20, 64'hCC);
    chk("t1_count", 128'(count), 128'(3));
    do_dump(1'b0, '0, '0);
    drain(0, 100, 1'b0);
    end_checks();
    DM_writeEnable = 1'b1;
    tick();
    DM_writeEnable = 1'b0;
    chk("t1_done_nostore", 128'(count), 128'(0));

    // Overflow: 20 stores into 16 entries.
    apply_reset(1'b0);
    for (int i = 0; i < 20; i++) store(64'h100 + 64'(i*8), 64'h5A5A_0000 ^ 64'(i));
    chk("t2_count", 128'(count),      128'(DEPTH));
    chk("t2_ovf",   128'(overflow),   128'(1));
    chk("t2_drop",  128'(drop_count), 128'(m_drops));
    do_dump(1'b0, '0, '0);
    drain(0, 100, 1'b0);
    end_checks();
    chk("t2_ovf_sticky", 128'(overflow), 128'(1));

    // Dump held through reset with nothing captured: straight to DONE.
    apply_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_valid", 128'(trace_valid), 128'(0));
      chk("t3_busy",  128'(busy),        128'(0));
    end
    dump = 1'b0;
    DM_writeEnable = 1'b1;
    tick();
    DM_writeEnable = 1'b0;
    chk("t3_done_nostore", 128'(count), 128'(0));
    chk("t3_valid_end",    128'(trace_valid), 128'(0));

    // Consumer stalls 5 cycles.
    apply_reset(1'b0);
    store(64'h1000, 64'h1);
    store(64'h2000, 64'h2);
    store(64'h3000, 64'h3);
    do_dump(1'b0, '0, '0);
    drain(5, 100, 1'b0);
    end_checks();

    // Store on the dump edge is last; stores during drain never appear.
    apply_reset(1'b0);
    store(64'h40, 64'h11);
    store(64'h48, 64'h22);
    do_dump(1'b1, 64'h50, 64'hDD);
    chk("t5_count", 128'(count), 128'(3));
    drain(0, 100, 1'b1);
    end_checks();

    // Reset in mid-drain discards everything.
    apply_reset(1'b0);
    for (int i = 0; i < 4; i++) store(64'h700 + 64'(i), 64'h900 + 64'(i));
    do_dump(1'b0, '0, '0);
    drain(0, 2, 1'b0);
    reset = 1'b1;
    #1;
    chk("t6_count", 128'(count),       128'(0));
    chk("t6_valid", 128'(trace_valid), 128'(0));
    chk("t6_busy",  128'(busy),        128'(0));
    tick();
    reset = 1'b0;
    sb.delete();
    store(64'hABC, 64'hDEF);
    chk("t6_count1", 128'(count), 128'(1));
    do_dump(1'b0, '0, '0);
    drain(0, 100, 1'b0);
    end_checks();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
